// File: rtl/ingr_stream_arbiter.sv
// ingr_stream_arbiter
//
// Packet-level round-robin arbiter. It merges NUM_SOURCES AXI-Stream inputs
// onto one ingress stream ahead of the tuser-strip stage. A grant is held for
// a whole packet, so beats of different packets never interleave. Every output
// beat carries the granted source index on tid and the source tdest unchanged.
// The datapath is a zero-latency mux. One IDLE arbitration cycle separates
// consecutive packets.
//
// Parameters:
//   NUM_SOURCES      number of input streams (2..16)
//   AXIS_BUS_WIDTH   tdata width; tkeep is AXIS_BUS_WIDTH/8
//   AXIS_DEST_WIDTH  tdest width per source
//
// Ports:
//   aclk, areset            clock (rising edge), async active-high reset
//   axis_in_*               flattened per-source streams, source i at slice i
//   axis_in_tuser           per-source error flag, sampled on the first beat
//   axis_in_tready          per-source ready; only the grantee can be non-zero
//   axis_out_*              merged stream; tid = granted source index
//   grant_active            a packet is in progress
//   grant_id                current or last granted source index
//   drop_count              (optional) saturating count of dropped packets
//
// Optional feature: define INGR_ARB_ERR_DROP_EN to discard packets whose first
// beat has tuser=1. This adds the DROP state and the drop_count port. In the
// default build tuser is ignored.

module ingr_stream_arbiter #(
  parameter int NUM_SOURCES     = 4,
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_DEST_WIDTH = 4,
  localparam int SRC_ID_WIDTH   = $clog2(NUM_SOURCES),
  localparam int KEEP_WIDTH     = AXIS_BUS_WIDTH / 8
) (
  input  logic                                    aclk,
  input  logic                                    areset,
  input  logic [NUM_SOURCES*AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [NUM_SOURCES-1:0]                  axis_in_tuser,
  input  logic [NUM_SOURCES*AXIS_DEST_WIDTH-1:0]  axis_in_tdest,
  input  logic [NUM_SOURCES*KEEP_WIDTH-1:0]       axis_in_tkeep,
  input  logic [NUM_SOURCES-1:0]                  axis_in_tlast,
  input  logic [NUM_SOURCES-1:0]                  axis_in_tvalid,
  output logic [NUM_SOURCES-1:0]                  axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]               axis_out_tdata,
  output logic [SRC_ID_WIDTH-1:0]                 axis_out_tid,
  output logic [AXIS_DEST_WIDTH-1:0]              axis_out_tdest,
  output logic [KEEP_WIDTH-1:0]                   axis_out_tkeep,
  output logic                                    axis_out_tlast,
  output logic                                    axis_out_tvalid,
  input  logic                                    axis_out_tready,
  output logic                                    grant_active,
  output logic [SRC_ID_WIDTH-1:0]                 grant_id
`ifdef INGR_ARB_ERR_DROP_EN
  ,
  output logic [15:0]                             drop_count
`endif
);

`ifdef INGR_ARB_ERR_DROP_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;
`endif

  localparam logic [SRC_ID_WIDTH-1:0] LAST_SRC = SRC_ID_WIDTH'(NUM_SOURCES - 1);

  state_t                      state;
  state_t                      state_next;
  logic [SRC_ID_WIDTH-1:0]     last_grant;
  logic [SRC_ID_WIDTH-1:0]     last_grant_next;
  logic [SRC_ID_WIDTH-1:0]     grant_id_next;

  logic                        req_found;
  logic [SRC_ID_WIDTH-1:0]     req_idx;
  logic [SRC_ID_WIDTH-1:0]     cand;

  logic [NUM_SOURCES-1:0]      grant_onehot;
  logic [AXIS_BUS_WIDTH-1:0]   sel_tdata;
  logic [KEEP_WIDTH-1:0]       sel_tkeep;
  logic [AXIS_DEST_WIDTH-1:0]  sel_tdest;
  logic                        sel_tlast;
  logic                        sel_tvalid;

`ifdef INGR_ARB_ERR_DROP_EN
  logic [15:0]                 drop_count_next;
`else
  logic                        unused_tuser;
  assign unused_tuser = ^axis_in_tuser;
`endif

  // Round-robin search: first valid source strictly after last_grant,
  // wrapping. With k running to NUM_SOURCES, last_grant itself is the final
  // candidate, so a lone requester is always served.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_SOURCES; k++) begin
      cand = SRC_ID_WIDTH'((32'(last_grant) + k) % NUM_SOURCES);
      if (!req_found && axis_in_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // Select the granted source's fields.
  always_comb begin
    grant_onehot = '0;
    sel_tdata    = '0;
    sel_tkeep    = '0;
    sel_tdest    = '0;
    sel_tlast    = 1'b0;
    sel_tvalid   = 1'b0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (SRC_ID_WIDTH'(i) == grant_id) begin
        grant_onehot[i] = 1'b1;
        sel_tdata       = axis_in_tdata[i*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
        sel_tkeep       = axis_in_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tdest       = axis_in_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
        sel_tlast       = axis_in_tlast[i];
        sel_tvalid      = axis_in_tvalid[i];
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next      = state;
    grant_id_next   = grant_id;
    last_grant_next = last_grant;
`ifdef INGR_ARB_ERR_DROP_EN
    drop_count_next = drop_count;
`endif
    axis_in_tready  = '0;
    axis_out_tdata  = '0;
    axis_out_tid    = '0;
    axis_out_tdest  = '0;
    axis_out_tkeep  = '0;
    axis_out_tlast  = 1'b0;
    axis_out_tvalid = 1'b0;
    grant_active    = 1'b0;

    case (state)
      IDLE: begin
        if (req_found) begin
          grant_id_next = req_idx;
          state_next    = PASS;
`ifdef INGR_ARB_ERR_DROP_EN
          if (axis_in_tuser[req_idx]) begin
            state_next = DROP;
          end
`endif
        end
      end

      PASS: begin
        grant_active    = 1'b1;
        axis_out_tdata  = sel_tdata;
        axis_out_tkeep  = sel_tkeep;
        axis_out_tdest  = sel_tdest;
        axis_out_tlast  = sel_tlast;
        axis_out_tvalid = sel_tvalid;
        axis_out_tid    = grant_id;
        axis_in_tready  = grant_onehot & {NUM_SOURCES{axis_out_tready}};
        if (sel_tvalid && axis_out_tready && sel_tlast) begin
          last_grant_next = grant_id;
          state_next      = IDLE;
        end
      end

`ifdef INGR_ARB_ERR_DROP_EN
      DROP: begin
        // Sink the grantee unconditionally; nothing reaches the output.
        grant_active   = 1'b1;
        axis_in_tready = grant_onehot;
        if (sel_tvalid && sel_tlast) begin
          last_grant_next = grant_id;
          state_next      = IDLE;
          if (drop_count != 16'hFFFF) begin
            drop_count_next = drop_count + 16'd1;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant_id   <= LAST_SRC;
      last_grant <= LAST_SRC;
`ifdef INGR_ARB_ERR_DROP_EN
      drop_count <= '0;
`endif
    end else begin
      state      <= state_next;
      grant_id   <= grant_id_next;
      last_grant <= last_grant_next;
`ifdef INGR_ARB_ERR_DROP_EN
      drop_count <= drop_count_next;
`endif
    end
  end

endmodule

// File: tb/tb_ingr_stream_arbiter.sv
// Testbench for ingr_stream_arbiter (NUM_SOURCES=4, 64-bit data, 4-bit tdest).
// A single driver process plays all four sources from per-source packet
// descriptor queues. Each beat it presents is pushed into that source's
// expected-beat queue. A monitor pops that queue on every output handshake.
// Arbitration order, the idle bubble and tready routing are derived from the
// round-robin rule applied to the requests seen in each idle cycle.

module tb_ingr_stream_arbiter;
  localparam int NS = 4;
  localparam int W  = 64;
  localparam int DW = 4;
  localparam int KW = 8;
  localparam int IW = 2;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NS*W-1:0]   in_tdata;
  logic [NS-1:0]     in_tuser;
  logic [NS*DW-1:0]  in_tdest;
  logic [NS*KW-1:0]  in_tkeep;
  logic [NS-1:0]     in_tlast;
  logic [NS-1:0]     in_tvalid;
  logic [NS-1:0]     in_tready;
  logic [W-1:0]      out_tdata;
  logic [IW-1:0]     out_tid;
  logic [DW-1:0]     out_tdest;
  logic [KW-1:0]     out_tkeep;
  logic              out_tlast;
  logic              out_tvalid;
  logic              out_tready;
  logic              grant_active;
  logic [IW-1:0]     grant_id;
`ifdef INGR_ARB_ERR_DROP_EN
  logic [15:0]       drop_count;
`endif

  always #5 aclk = ~aclk;

  ingr_stream_arbiter #(
    .NUM_SOURCES    (NS),
    .AXIS_BUS_WIDTH (W),
    .AXIS_DEST_WIDTH(DW)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .axis_in_tdata  (in_tdata),
    .axis_in_tuser  (in_tuser),
    .axis_in_tdest  (in_tdest),
    .axis_in_tkeep  (in_tkeep),
    .axis_in_tlast  (in_tlast),
    .axis_in_tvalid (in_tvalid),
    .axis_in_tready (in_tready),
    .axis_out_tdata (out_tdata),
    .axis_out_tid   (out_tid),
    .axis_out_tdest (out_tdest),
    .axis_out_tkeep (out_tkeep),
    .axis_out_tlast (out_tlast),
    .axis_out_tvalid(out_tvalid),
    .axis_out_tready(out_tready),
    .grant_active   (grant_active),
    .grant_id       (grant_id)
`ifdef INGR_ARB_ERR_DROP_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  typedef struct {
    int            len;
    logic [DW-1:0] dest;
    bit            user;
    int            delay;
  } desc_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    bit            last;
    logic [DW-1:0] dest;
  } beat_t;

  desc_t dq[NS][$];
  beat_t exq[NS][$];

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;      // out_tready: 0 always high, 1 random, 2 pattern 1,0,0,1
  bit gap_en = 1'b0;  // random idle gaps between beats of a packet

  // driver state
  bit    act[NS];
  int    bidx[NS];
  int    wait_c[NS];
  desc_t cur[NS];
  int    in_hs[NS];

  // reference model state
  bit m_busy;
  bit m_drop;
  int m_grant;
  int m_last;
  int m_drops;
  int hs_count;
  int start_q[$];

  function automatic void chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act_v, exp_v, $time);
    end
  endfunction

  task automatic add(int s, int len, int dest, bit user, int delay);
    desc_t d;
    d.len   = len;
    d.dest  = DW'(dest);
    d.user  = user;
    d.delay = delay;
    dq[s].push_back(d);
  endtask

  function automatic bit all_idle();
    bit r = !m_busy;
    for (int s = 0; s < NS; s++) begin
      if (dq[s].size() != 0 || act[s] || exq[s].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic drain(string name, int limit);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < limit) begin
      @(negedge aclk); #1;
      n++;
      if (all_idle()) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 3) begin
      n_bad++;
      $display("FAIL %s_drain: traffic pending after %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic chk_order(string name, int exp_q[$]);
    chk({name, "_npkts"}, start_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < start_q.size(); i++) begin
      chk({name, "_order"}, start_q[i], exp_q[i]);
    end
  endtask

  task automatic reset_pulse();
    @(posedge aclk); #2 areset = 1'b1;
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
  endtask

  // out_tready generator
  initial begin : rdy_gen
    int cyc;
    cyc = 0;
    out_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      cyc++;
      case (mode)
        0:       out_tready = 1'b1;
        1:       out_tready = ($urandom_range(0, 3) != 0);
        default: out_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
    end
  end

  // source driver: all four sources in one process
  initial begin : src_drv
    logic [NS-1:0] hs;
    beat_t b;
    in_tdata  = '0;
    in_tuser  = '0;
    in_tdest  = '0;
    in_tkeep  = '0;
    in_tlast  = '0;
    in_tvalid = '0;
    for (int s = 0; s < NS; s++) begin
      act[s] = 1'b0; bidx[s] = 0; wait_c[s] = 0; in_hs[s] = 0;
    end
    forever begin
      @(negedge aclk);
      hs = in_tvalid & in_tready;
      @(posedge aclk); #1;
      if (areset) begin
        in_tvalid = '0;
        in_tlast  = '0;
        in_tuser  = '0;
        for (int s = 0; s < NS; s++) act[s] = 1'b0;
        continue;
      end
      for (int s = 0; s < NS; s++) begin
        if (act[s] && hs[s]) begin
          in_hs[s]++;
          bidx[s]++;
          in_tvalid[s] = 1'b0;
          if (bidx[s] == cur[s].len) act[s] = 1'b0;
          else wait_c[s] = (gap_en && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        end
        if (!act[s] && dq[s].size() > 0) begin
          cur[s]    = dq[s].pop_front();
          act[s]    = 1'b1;
          bidx[s]   = 0;
          wait_c[s] = cur[s].delay;
        end
        if (act[s] && !in_tvalid[s]) begin
          if (wait_c[s] > 0) begin
            wait_c[s]--;
          end else begin
            b.data = {$urandom, $urandom};
            b.last = (bidx[s] == cur[s].len - 1);
            b.keep = b.last ? KW'($urandom_range(1, 255)) : '1;
            b.dest = cur[s].dest;
            in_tdata[s*W +: W]   = b.data;
            in_tkeep[s*KW +: KW] = b.keep;
            in_tdest[s*DW +: DW] = b.dest;
            in_tlast[s]  = b.last;
            in_tuser[s]  = cur[s].user;
            in_tvalid[s] = 1'b1;
            if (!cur[s].user) exq[s].push_back(b);
          end
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin : mon
    beat_t b;
    int w;
    m_busy = 1'b0; m_drop = 1'b0; m_grant = 0; m_last = NS - 1;
    m_drops = 0; hs_count = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_busy = 1'b0; m_drop = 1'b0; m_last = NS - 1; m_drops = 0;
        for (int s = 0; s < NS; s++) exq[s].delete();
        continue;
      end
      if (!m_busy) begin
        chk("idle_tvalid", out_tvalid, 0);
        chk("idle_in_tready", in_tready, 0);
        chk("idle_grant_active", grant_active, 0);
        chk("idle_grant_id", grant_id, m_last);
        if (|in_tvalid) begin
          w = 0;
          for (int k = 1; k <= NS; k++) begin
            if (in_tvalid[(m_last + k) % NS]) begin
              w = (m_last + k) % NS;
              break;
            end
          end
          m_grant = w;
          m_busy  = 1'b1;
          m_drop  = 1'b0;
`ifdef INGR_ARB_ERR_DROP_EN
          m_drop  = in_tuser[w];
`endif
          start_q.push_back(w);
        end
      end else begin
        chk("busy_grant_active", grant_active, 1);
        chk("busy_grant_id", grant_id, m_grant);
        if (m_drop) begin
          chk("drop_tvalid", out_tvalid, 0);
          chk("drop_in_tready", in_tready, 1 << m_grant);
          if (in_tvalid[m_grant] && in_tlast[m_grant]) begin
            m_busy = 1'b0; m_last = m_grant; m_drops++;
          end
        end else begin
          chk("out_tvalid", out_tvalid, in_tvalid[m_grant]);
          chk("in_tready", in_tready, out_tready ? (1 << m_grant) : 0);
          if (out_tvalid && exq[m_grant].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_beat: got a beat from source %0d, expected none", m_grant);
          end else if (out_tvalid && !out_tready) begin
            chk("stall_tdata", out_tdata, exq[m_grant][0].data);
            chk("stall_tlast", out_tlast, exq[m_grant][0].last);
          end else if (out_tvalid && out_tready) begin
            hs_count++;
            b = exq[m_grant].pop_front();
            chk("beat_tdata", out_tdata, b.data);
            chk("beat_tkeep", out_tkeep, b.keep);
            chk("beat_tlast", out_tlast, b.last);
            chk("beat_tdest", out_tdest, b.dest);
            chk("beat_tid", out_tid, m_grant);
            if (b.last) begin
              m_busy = 1'b0; m_last = m_grant;
            end
          end
        end
      end
    end
  end

  // main sequence
  initial begin : main_seq
    int h0;
    int n;
    int e[$];
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", out_tvalid, 0);
    chk("reset_in_tready", in_tready, 0);
    chk("reset_grant_active", grant_active, 0);
    chk("reset_grant_id", grant_id, NS - 1);
`ifdef INGR_ARB_ERR_DROP_EN
    chk("reset_drop_count", drop_count, 0);
`endif
    #1 areset = 1'b0;

    // single 3-beat packet from source 2, tdest 5
    start_q.delete();
    h0 = hs_count;
    add(2, 3, 5, 1'b0, 0);
    drain("src2", 200);
    chk("src2_beats", hs_count - h0, 3);
    chk("src2_grant_id", grant_id, 2);
    e = '{2};
    chk_order("src2", e);

    // all sources continuously valid with 1-beat packets
    reset_pulse();
    start_q.delete();
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NS; s++) add(s, 1, s + 8, 1'b0, 0);
    drain("rr", 400);
    e = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    chk_order("rr", e);

    // source 0 requests while source 1 is mid-packet
    reset_pulse();
    start_q.delete();
    add(1, 4, 3, 1'b0, 0);
    add(0, 1, 7, 1'b0, 3);
    drain("lock", 200);
    e = '{1, 0};
    chk_order("lock", e);

    // backpressure pattern during a 5-beat packet
    mode = 2;
    start_q.delete();
    add(3, 5, 12, 1'b0, 0);
    drain("bp", 300);
    e = '{3};
    chk_order("bp", e);
    mode = 0;

    // reset asserted during beat 2 of 5
    reset_pulse();
    h0 = hs_count;
    add(1, 5, 2, 1'b0, 0);
    n = 0;
    while (hs_count == h0 && n < 100) begin
      @(negedge aclk); #1;
      n++;
    end
    chk("midrst_first_beat", hs_count - h0, 1);
    @(negedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("midrst_tvalid", out_tvalid, 0);
    chk("midrst_tlast", out_tlast, 0);
    chk("midrst_in_tready", in_tready, 0);
    chk("midrst_grant_active", grant_active, 0);
    chk("midrst_grant_id", grant_id, NS - 1);
    repeat (2) @(posedge aclk);
    #2 areset = 1'b0;
    start_q.delete();
    add(1, 1, 4, 1'b0, 0);
    add(0, 1, 6, 1'b0, 0);
    drain("postrst", 200);
    e = '{0, 1};
    chk_order("postrst", e);

`ifdef INGR_ARB_ERR_DROP_EN
    // errored packet from source 3 is discarded, a clean one follows
    reset_pulse();
    h0 = hs_count;
    n = in_hs[3];
    add(3, 4, 1, 1'b1, 0);
    add(3, 2, 9, 1'b0, 0);
    drain("drop", 300);
    chk("drop_count_one", drop_count, 1);
    chk("drop_out_beats", hs_count - h0, 2);
    chk("drop_in_handshakes", in_hs[3] - n, 6);
`endif

    // randomized traffic with random backpressure and gaps
    mode = 1;
    gap_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      bit u;
      u = 1'b0;
`ifdef INGR_ARB_ERR_DROP_EN
      u = ($urandom_range(0, 5) == 0);
`endif
      add($urandom_range(0, NS - 1), $urandom_range(1, 5), $urandom_range(0, 15), u,
          $urandom_range(0, 3));
    end
    drain("random", 5000);
`ifdef INGR_ARB_ERR_DROP_EN
    chk("random_drop_count", drop_count, m_drops);
`endif
    mode = 0;
    gap_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
